// File: rtl/lm_sm_sequencer_if.sv
// Handshake and memory/register-file bus between the main controller and the
// LM/SM transfer sequencer. The controller side is the master.
interface lm_sm_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
);
  logic              start;
  logic              is_store;
  logic [NREG-1:0]   reg_mask;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        rf_idx;
  logic              rf_wen;
  logic [3:0]        xfer_cnt;

  modport master (
    output start, is_store, reg_mask, base_addr, mem_ready,
    input  busy, done, mem_addr, mem_read, mem_write, rf_idx, rf_wen, xfer_cnt
  );

  modport slave (
    input  start, is_store, reg_mask, base_addr, mem_ready,
    output busy, done, mem_addr, mem_read, mem_write, rf_idx, rf_wen, xfer_cnt
  );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load-multiple / store-multiple sequencer. Walks a latched register mask from
// R0 upward and issues one memory access per set bit at consecutive addresses
// starting at the latched base. State advances on the falling clock edge so it
// lines up with the main controller's timing.
module lm_sm_sequencer #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 8
) (
  input  logic               clk,
  input  logic               proc_rst,
  lm_sm_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [NREG-1:0] MASK_ONE = {{(NREG-1){1'b0}}, 1'b1};

  state_t            state_q,    state_d;
  logic [NREG-1:0]   mask_q,     mask_d;
  logic [ADDR_W-1:0] base_q,     base_d;
  logic              store_q,    store_d;
  logic [3:0]        off_q,      off_d;
  logic [3:0]        xfer_q,     xfer_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [2:0]        rf_idx_q,   rf_idx_d;
  logic [NREG-1:0]   clr_mask_s;

  // Index of the lowest set bit; the walk always proceeds from R0 upward.
  function automatic logic [2:0] lowest_set(input logic [NREG-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next-state and datapath updates for the IDLE/SCAN/ACCESS/DONE walk.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    base_d     = base_q;
    store_d    = store_q;
    off_d      = off_q;
    xfer_d     = xfer_q;
    mem_addr_d = mem_addr_q;
    rf_idx_d   = rf_idx_q;
    clr_mask_s = mask_q & ~(MASK_ONE << rf_idx_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d  = bus.reg_mask;
          base_d  = bus.base_addr;
          store_d = bus.is_store;
          off_d   = 4'd0;
          xfer_d  = 4'd0;
          if (bus.reg_mask != {NREG{1'b0}}) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Address is base plus transfer count, wrapping at the top of memory.
        rf_idx_d   = lowest_set(mask_q);
        mem_addr_d = base_q + {{(ADDR_W-4){1'b0}}, off_q};
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (bus.mem_ready) begin
          mask_d = clr_mask_s;
          off_d  = off_q + 4'd1;
          xfer_d = xfer_q + 4'd1;
          if (clr_mask_s != {NREG{1'b0}}) begin
            state_d = ST_SCAN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, falling-edge clocked with async reset.
  always_ff @(negedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      state_q    <= ST_IDLE;
      mask_q     <= {NREG{1'b0}};
      base_q     <= {ADDR_W{1'b0}};
      store_q    <= 1'b0;
      off_q      <= 4'd0;
      xfer_q     <= 4'd0;
      mem_addr_q <= {ADDR_W{1'b0}};
      rf_idx_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      base_q     <= base_d;
      store_q    <= store_d;
      off_q      <= off_d;
      xfer_q     <= xfer_d;
      mem_addr_q <= mem_addr_d;
      rf_idx_q   <= rf_idx_d;
    end
  end

  // Status and strobes decode directly from the registered state so a reset
  // removes every strobe immediately.
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.mem_read  = (state_q == ST_ACCESS) & ~store_q;
  assign bus.mem_write = (state_q == ST_ACCESS) &  store_q;
  assign bus.rf_wen    = (state_q == ST_ACCESS) & ~store_q & bus.mem_ready;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rf_idx    = rf_idx_q;
  assign bus.xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for the LM/SM sequencer. The DUT updates on the falling edge, so
// inputs are driven just after each rising edge and outputs sampled 1ns later.
// Expected behaviour is an explicit per-cycle trace built from the transfer
// list: one quiet cycle per register, then the access held through its stall,
// then a single done cycle.
module tb_lm_sm_sequencer;

  logic clk;
  logic proc_rst;
  int   checks;
  int   errors;

  // Bench-side memory of what the address/index/count outputs last held.
  logic [15:0] m_addr;
  logic [2:0]  m_idx;
  logic [3:0]  m_cnt;

  lm_sm_sequencer_if #(.ADDR_W(16), .NREG(8)) bus ();

  lm_sm_sequencer #(.ADDR_W(16), .NREG(8)) dut (
    .clk      (clk),
    .proc_rst (proc_rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] observe();
    return {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.rf_wen,
            bus.mem_addr, bus.rf_idx, bus.xfer_cnt};
  endfunction

  // Run one operation: build the expected cycle trace, then drive and compare.
  task automatic do_transfer(input logic [7:0] mask, input logic [15:0] base,
                             input logic st, input int max_stall,
                             input bit rand_stall, input bit noisy,
                             input string name);
    logic [27:0] exp_q[$];
    logic        rdy_q[$];
    logic [2:0]  idxs[$];
    int          stalls[$];
    logic [27:0] obs;
    logic [15:0] a;
    logic [2:0]  ix;
    int k, done_seen, wen_seen, done_at, exp_done_at;

    for (int b = 0; b < 8; b++) begin
      if (mask[b]) begin
        idxs.push_back(3'(b));
        stalls.push_back(rand_stall ? int'($urandom_range(max_stall, 0)) : max_stall);
      end
    end
    k = idxs.size();

    a  = m_addr;
    ix = m_idx;
    exp_q.push_back({5'b0, a, ix, m_cnt});
    rdy_q.push_back(1'($urandom));
    for (int i = 0; i < k; i++) begin
      exp_q.push_back({1'b1, 4'b0, a, ix, 4'(i)});
      rdy_q.push_back(1'($urandom));
      a  = base + 16'(i);
      ix = idxs[i];
      for (int s = 0; s <= stalls[i]; s++) begin
        exp_q.push_back({1'b1, 1'b0, ~st, st, (~st) & (s == stalls[i]), a, ix, 4'(i)});
        rdy_q.push_back(s == stalls[i]);
      end
    end
    exp_q.push_back({2'b11, 3'b0, a, ix, 4'(k)});
    rdy_q.push_back(1'($urandom));
    exp_done_at = exp_q.size() - 1;

    done_seen = 0;
    wen_seen  = 0;
    done_at   = -1;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clk);
      if (j == 0) begin
        bus.start     = 1'b1;
        bus.reg_mask  = mask;
        bus.base_addr = base;
        bus.is_store  = st;
      end else begin
        bus.start     = noisy ? 1'($urandom) : 1'b0;
        bus.reg_mask  = 8'($urandom);
        bus.base_addr = 16'($urandom);
        bus.is_store  = 1'($urandom);
      end
      bus.mem_ready = rdy_q[j];
      #1;
      obs = observe();
      checks++;
      if (obs !== exp_q[j]) begin
        errors++;
        $display("FAIL %s cyc=%0d got busy=%b done=%b rd=%b wr=%b wen=%b addr=%h idx=%0d cnt=%0d required busy=%b done=%b rd=%b wr=%b wen=%b addr=%h idx=%0d cnt=%0d",
                 name, j, obs[27], obs[26], obs[25], obs[24], obs[23], obs[22:7], obs[6:4], obs[3:0],
                 exp_q[j][27], exp_q[j][26], exp_q[j][25], exp_q[j][24], exp_q[j][23],
                 exp_q[j][22:7], exp_q[j][6:4], exp_q[j][3:0]);
      end
      if (bus.done === 1'b1) begin
        done_seen++;
        if (done_at < 0) done_at = j;
      end
      if (bus.rf_wen === 1'b1) wen_seen++;
    end
    bus.start = 1'b0;

    m_addr = a;
    m_idx  = ix;
    m_cnt  = 4'(k);

    checks++;
    if (done_at != exp_done_at) begin
      errors++;
      $display("FAIL %s_latency got done at cycle %0d required %0d", name, done_at, exp_done_at);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("FAIL %s_done_count got %0d required 1", name, done_seen);
    end
    checks++;
    if (wen_seen != (st ? 0 : k)) begin
      errors++;
      $display("FAIL %s_wen_count got %0d required %0d", name, wen_seen, st ? 0 : k);
    end
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    proc_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = observe();
    checks++;
    if (obs !== 28'h0) begin
      errors++;
      $display("FAIL reset_state got %h required %h", obs, 28'h0);
    end
    proc_rst = 1'b1;
    @(posedge clk);
    bus.mem_ready = 1'b1;
    #1;
    obs = observe();
    checks++;
    if (obs !== 28'h0) begin
      errors++;
      $display("FAIL reset_idle got %h required %h", obs, 28'h0);
    end
  endtask

  task automatic test_zero_mask();
    logic [27:0] obs;
    logic [27:0] exp_v;
    do_transfer(8'h00, 16'h1234, 1'b0, 0, 1'b0, 1'b0, "zero_mask");
    @(posedge clk);
    bus.mem_ready = 1'b1;
    #1;
    obs   = observe();
    exp_v = {5'b0, m_addr, m_idx, 4'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL zero_mask_idle got %h required %h", obs, exp_v);
    end
  endtask

  task automatic test_lm_sparse();
    do_transfer(8'hA5, 16'h0040, 1'b0, 0, 1'b0, 1'b0, "lm_sparse");
  endtask

  task automatic test_sm_stall();
    do_transfer(8'hFF, 16'h1000, 1'b1, 2, 1'b0, 1'b0, "sm_stall");
  endtask

  task automatic test_wrap();
    do_transfer(8'h07, 16'hFFFE, 1'b0, 0, 1'b0, 1'b0, "addr_wrap");
  endtask

  task automatic test_busy_ignore();
    do_transfer(8'h3C, 16'h0200, 1'b0, 1, 1'b1, 1'b1, "start_busy");
  endtask

  task automatic test_back_to_back();
    do_transfer(8'h81, 16'h0500, 1'b1, 0, 1'b0, 1'b0, "b2b_a");
    do_transfer(8'h84, 16'h0600, 1'b0, 0, 1'b0, 1'b0, "b2b_b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      do_transfer(($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom),
                  16'($urandom), 1'($urandom), 3, 1'b1, 1'b1, "random");
    end
  endtask

  task automatic test_reset_midop();
    logic [27:0] obs;
    logic [27:0] exp_v;
    logic [15:0] base;
    base = 16'($urandom);
    @(posedge clk);
    bus.start     = 1'b1;
    bus.reg_mask  = 8'h0F;
    bus.base_addr = base;
    bus.is_store  = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      bus.start = 1'b0;
    end
    #1;
    obs   = observe();
    exp_v = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, base + 16'd1, 3'd1, 4'd1};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL midop_second_access got %h required %h", obs, exp_v);
    end
    proc_rst = 1'b0;
    #1;
    obs = observe();
    checks++;
    if (obs !== 28'h0) begin
      errors++;
      $display("FAIL midop_reset got %h required %h", obs, 28'h0);
    end
    @(posedge clk);
    #1;
    proc_rst = 1'b1;
    m_addr = 16'h0;
    m_idx  = 3'd0;
    m_cnt  = 4'd0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      bus.mem_ready = 1'($urandom);
      bus.reg_mask  = 8'($urandom);
      #1;
      obs = observe();
      checks++;
      if (obs !== 28'h0) begin
        errors++;
        $display("FAIL midop_after_release cyc=%0d got %h required %h", c, obs, 28'h0);
      end
    end
    do_transfer(8'h0F, base, 1'b0, 0, 1'b0, 1'b0, "midop_restart");
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    m_addr        = 16'h0;
    m_idx         = 3'd0;
    m_cnt         = 4'd0;
    proc_rst      = 1'b0;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.reg_mask  = 8'h00;
    bus.base_addr = 16'h0;
    bus.mem_ready = 1'b0;

    test_reset();
    test_zero_mask();
    test_lm_sparse();
    test_sm_stall();
    test_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
